// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers in-order responses and
// presents {instr, pc, pc+4} to decode, honouring decode stall and execute-stage flush.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_four
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   tag_mem   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, tag_rd_ptr, tag_wr_ptr;
  logic [CW-1:0] count, inflight, discard, inflight_nx;
  logic [CW:0]   occupancy;
  logic [31:0]   target_aligned;
  logic          issue, drop, push, pop;

  assign target_aligned = flush_target & 32'hFFFF_FFFC;
  assign occupancy      = {1'b0, count} + {1'b0, inflight};

  // Issue only when a FIFO slot is reserved for every outstanding request
  assign imem_req_valid = !rst && !flush && (occupancy < DEPTH_L);
  assign imem_req_addr  = fetch_pc;
  assign issue          = imem_req_valid && imem_req_ready;

  assign drop        = (discard != '0);
  assign push        = imem_resp_valid && !drop && !flush && !rst;
  assign pop         = out_valid && !stall && !flush && !rst;
  assign inflight_nx = inflight + CW'(issue) - CW'(imem_resp_valid);

  assign out_valid        = (count != '0);
  assign out_instr        = out_valid ? instr_mem[rd_ptr] : NOP;
  assign out_pc           = out_valid ? pc_mem[rd_ptr] : 32'h0;
  assign out_pc_plus_four = out_pc + 32'd4;

  // After reset or flush every outstanding response belongs to the old stream, so discard
  // tracks inflight exactly; this keeps back-to-back flushes from double counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC & 32'hFFFF_FFFC;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      tag_rd_ptr <= '0;
      tag_wr_ptr <= '0;
      inflight   <= inflight_nx;
      discard    <= inflight_nx;
    end else if (flush) begin
      fetch_pc   <= target_aligned;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      tag_rd_ptr <= '0;
      tag_wr_ptr <= '0;
      inflight   <= inflight_nx;
      discard    <= inflight_nx;
    end else begin
      if (issue) begin
        fetch_pc   <= fetch_pc + 32'd4;
        tag_wr_ptr <= tag_wr_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        tag_rd_ptr <= tag_rd_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
      inflight <= inflight_nx;
      if (imem_resp_valid && drop)
        discard <= discard - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (issue)
      tag_mem[tag_wr_ptr] <= fetch_pc;
    if (push) begin
      instr_mem[wr_ptr] <= imem_resp_data;
      pc_mem[wr_ptr]    <= tag_mem[tag_rd_ptr];
    end
  end

endmodule
